ks_sub_pipe_32b: RTL
====================

Name: ks_sub_pipe_32b

Overview:
- Pipelined 32-bit unsigned/two's-complement subtractor, D = X - Y, built on a Kogge-Stone parallel-prefix carry network.
- Inverse-direction companion to the team's combinational 32-bit KS adder; shares the same GP-generator / carry-operator structure.
- Subtraction is computed as X + ~Y + 1: Cin tied to 1, Y inverted at the GP stage.
- Registered 3-stage pipeline with valid/ready handshake on both sides; sits between operand-fetch and writeback in the datapath.

Parameters:
- WIDTH, 32, operand width; only 32 is supported; prefix depth is fixed at 5 levels.
- LAT, 3, pipeline latency in cycles; informational only, must equal 3.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous active-high reset.
- IN_VALID  input  1  operand pair valid.
- IN_READY  output  1  block accepts operands this cycle.
- X  input  32  minuend.
- Y  input  32  subtrahend.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  downstream accepts result.
- D  output  32  difference, X - Y mod 2^32.
- BOUT  output  1  borrow out; 1 iff X < Y unsigned; equals ~carry-out of X + ~Y + 1.

Behaviour:
- Reset: async on RST high. All stage-valid flags, OUT_VALID, D and BOUT clear to 0. IN_READY reads 1 while RST is low and the pipe is empty. Data registers also clear, so D = 0 after reset.
- Stage S1 registers P0 = X ^ ~Y and G0 = X & ~Y (32 bits each), plus valid v1.
- Stage S2 applies prefix levels 1-3 (spans 1, 2, 4) to S1 and registers G3/P3 plus P0, plus valid v2.
- Stage S3 applies levels 4-5 (spans 8, 16) and the sum/carry equations with Cin = 1, then registers D, BOUT and v3.
  - c[i+1] = G5[i] | P5[i].
  - D[0] = ~P0[0].
  - D[i] = c[i] ^ P0[i].
  - BOUT = ~(G5[31] | P5[31]).
- OUT_VALID = v3. D and BOUT are driven straight from the S3 registers.
- Flow control: advance = ~v3 | OUT_READY, and IN_READY = advance (global stall).
  - When advance = 1, every stage shifts forward one slot; bubbles propagate.
  - When advance = 0, all stages hold their contents.
- Handshakes:
  - Input transfer occurs when IN_VALID & IN_READY; v1 next = IN_VALID & advance.
  - Output transfer occurs when OUT_VALID & OUT_READY.
- Latency: 3 cycles from input transfer to OUT_VALID with no stall. Throughput is 1 result per cycle while OUT_READY stays high.
- Simultaneous in/out transfer in the same cycle is legal. The pipe holds at most 3 entries and never drops or duplicates one.
- While OUT_VALID = 1 and OUT_READY = 0: D and BOUT stay stable, and IN_READY = 0.
- X and Y are sampled only on an input transfer. Values present when IN_READY = 0 are ignored.
- RST asserted mid-operation flushes all in-flight entries immediately (async). No partial result appears after deassert.
- Boundaries:
  - X = Y gives D = 0, BOUT = 0.
  - 0 - 1 gives D = 0xFFFFFFFF, BOUT = 1.
  - 0x80000000 - 1 gives 0x7FFFFFFF, BOUT = 0.

Optional Feature:
- Macro KS_SUB_STATUS_EN.
- Defined:
  - Adds output Z (1 bit): D == 0.
  - Adds output OVF (1 bit): signed overflow = (X[31] ^ Y[31]) & (X[31] ^ D[31]).
  - X[31] and Y[31] are carried through S1/S2 to compute OVF.
  - Both outputs are registered in S3 alongside D, reset to 0, and valid only with OUT_VALID.
- Undefined: the ports and the sign-bit pipeline registers are absent. All other behaviour is identical.

Test Plan:
- Reset then single op, OUT_READY = 1: X = 0x00000005, Y = 0x00000003 at cycle 0 -> OUT_VALID at cycle 3 with D = 0x00000002, BOUT = 0. OUT_VALID is 0 in cycles 1-2.
- Borrow chain: X = 0x00000000, Y = 0x00000001 -> D = 0xFFFFFFFF, BOUT = 1. With KS_SUB_STATUS_EN: Z = 0, OVF = 0.
- Back-to-back streaming: 100 random pairs on consecutive cycles, OUT_READY = 1 -> 100 results in order, each equal to (X - Y) mod 2^32 with BOUT = (X < Y), one per cycle starting at cycle 3.
- Backpressure: stream 5 pairs, hold OUT_READY = 0 for 4 cycles after the first result -> IN_READY = 0 while stalled, D stable, no loss. All 5 results emerge in order after release.
- Signed overflow (KS_SUB_STATUS_EN): X = 0x80000000, Y = 0x00000001 -> D = 0x7FFFFFFF, OVF = 1, BOUT = 0. Separately, X = Y = 0x12345678 -> D = 0, Z = 1.
- Async reset mid-flight: 3 ops in flight, pulse RST between clock edges -> OUT_VALID and D = 0 immediately. No stale result appears after RST deasserts; the next op completes in 3 cycles.

Source files
------------

// File: rtl/ks_sub_pipe_32b.sv
// ks_sub_pipe_32b: 3-stage pipelined 32-bit subtractor D = X - Y on a Kogge-Stone prefix network.
// Optional macro KS_SUB_STATUS_EN adds registered zero (Z) and signed-overflow (OVF) flags.
module ks_sub_pipe_32b #(
    parameter int WIDTH = 32,
    parameter int LAT   = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] D,
    output logic             BOUT
`ifdef KS_SUB_STATUS_EN
    ,
    output logic             Z,
    output logic             OVF
`endif
);

    if (WIDTH != 32 || LAT != 3) begin : g_cfg_check
        $error("ks_sub_pipe_32b supports only WIDTH=32 and LAT=3");
    end

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
    } gp_t;

    // One Kogge-Stone level: bits below the span already hold their full group terms.
    function automatic gp_t ks_level(input gp_t a, input int span);
        gp_t r;
        r = a;
        for (int i = span; i < WIDTH; i++) begin
            r.g[i] = a.g[i] | (a.p[i] & a.g[i-span]);
            r.p[i] = a.p[i] & a.p[i-span];
        end
        return r;
    endfunction

    // Sum with carry-in forced to 1; result is {carry_out, difference}.
    function automatic logic [WIDTH:0] sum_cin1(input gp_t gp, input logic [WIDTH-1:0] p0);
        logic [WIDTH:0]   c;
        logic [WIDTH-1:0] s;
        c[0] = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            c[i+1] = gp.g[i] | gp.p[i];
            s[i]   = c[i] ^ p0[i];
        end
        return {c[WIDTH], s};
    endfunction

    logic             advance;
    logic             vld_p0;
    logic             vld_p1;
    logic             vld_p2;
    logic [WIDTH-1:0] g0_p0;
    logic [WIDTH-1:0] p0_p0;
    logic [WIDTH-1:0] g3_p1;
    logic [WIDTH-1:0] p3_p1;
    logic [WIDTH-1:0] p0_p1;
    logic [WIDTH-1:0] d_p2;
    logic             bout_p2;
    gp_t              gp0;
    gp_t              gp3;
    gp_t              gp3_reg;
    gp_t              gp5;
    logic [WIDTH:0]   sum;

    assign advance   = ~vld_p2 | OUT_READY;
    assign IN_READY  = advance;
    assign OUT_VALID = vld_p2;
    assign D         = d_p2;
    assign BOUT      = bout_p2;

    // Stage S1: generate/propagate of X + ~Y
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_p0 <= 1'b0;
            g0_p0  <= '0;
            p0_p0  <= '0;
        end else if (advance) begin
            vld_p0 <= IN_VALID;
            if (IN_VALID) begin
                g0_p0 <= X & ~Y;
                p0_p0 <= X ^ ~Y;
            end
        end
    end

    // Stage S2: prefix levels 1-3 (spans 1, 2, 4)
    always_comb begin
        gp0 = {g0_p0, p0_p0};
        gp3 = ks_level(ks_level(ks_level(gp0, 1), 2), 4);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_p1 <= 1'b0;
            g3_p1  <= '0;
            p3_p1  <= '0;
            p0_p1  <= '0;
        end else if (advance) begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                g3_p1 <= gp3.g;
                p3_p1 <= gp3.p;
                p0_p1 <= p0_p0;
            end
        end
    end

    // Stage S3: prefix levels 4-5 (spans 8, 16) and the final sum
    always_comb begin
        gp3_reg = {g3_p1, p3_p1};
        gp5     = ks_level(ks_level(gp3_reg, 8), 16);
        sum     = sum_cin1(gp5, p0_p1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_p2  <= 1'b0;
            d_p2    <= '0;
            bout_p2 <= 1'b0;
        end else if (advance) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                d_p2    <= sum[WIDTH-1:0];
                bout_p2 <= ~sum[WIDTH];
            end
        end
    end

`ifdef KS_SUB_STATUS_EN
    logic xs_p0;
    logic ys_p0;
    logic xs_p1;
    logic ys_p1;
    logic z_p2;
    logic ovf_p2;

    assign Z   = z_p2;
    assign OVF = ovf_p2;

    // Operand sign bits ride alongside the data for the overflow flag in S3.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            xs_p0  <= 1'b0;
            ys_p0  <= 1'b0;
            xs_p1  <= 1'b0;
            ys_p1  <= 1'b0;
            z_p2   <= 1'b0;
            ovf_p2 <= 1'b0;
        end else if (advance) begin
            if (IN_VALID) begin
                xs_p0 <= X[WIDTH-1];
                ys_p0 <= Y[WIDTH-1];
            end
            if (vld_p0) begin
                xs_p1 <= xs_p0;
                ys_p1 <= ys_p0;
            end
            if (vld_p1) begin
                z_p2   <= (sum[WIDTH-1:0] == '0);
                ovf_p2 <= (xs_p1 ^ ys_p1) & (xs_p1 ^ sum[WIDTH-1]);
            end
        end
    end
`endif

endmodule
